// File: rtl/wb_stream_dma_pkg.sv
// Shared constants and types for the Wishbone memory-to-stream DMA writer:
// bus cycle-type codes, config register map, CTRL bit positions and FSM states.
package wb_stream_dma_pkg;

    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_EOB = 3'b111;

    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_START_ADR  = 3'd1;
    localparam logic [2:0] REG_BUF_SIZE   = 3'd2;
    localparam logic [2:0] REG_BURST_SIZE = 3'd3;
    localparam logic [2:0] REG_TX_CNT     = 3'd4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 1;
    localparam int CTRL_ERR    = 2;
    localparam int CTRL_DONE   = 3;
    localparam int CTRL_IRQ_EN = 4;
    localparam int CTRL_LOOP   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } dma_state_e;

endpackage

// File: rtl/wb_stream_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count,
// used to buffer fetched bus words (plus end-of-buffer flag) ahead of the serialiser.
module wb_stream_sync_fifo #(
    parameter int DW = 33,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic [AW:0]   cnt
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (cnt == '0);
    assign do_wr   = wr_en & (cnt != (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/wb_stream_dma_writer.sv
// Memory-to-stream DMA: Wishbone burst reads into a FIFO, serialised onto a narrower stream.
// Ring/loop mode is compiled in only when WB_STREAM_DMA_LOOP_EN is defined.
module wb_stream_dma_writer
    import wb_stream_dma_pkg::*;
#(
    parameter int WB_DW         = 32,
    parameter int WB_AW         = 32,
    parameter int OUT_DW        = 8,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2 ** FIFO_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    output logic [OUT_DW-1:0]    stream_m_data_o,
    output logic                 stream_m_valid_o,
    input  logic                 stream_m_ready_i,
    output logic                 stream_m_last_o,
    output logic                 irq_o,
    input  logic [4:0]           wbs_adr_i,
    input  logic [WB_DW-1:0]     wbs_dat_i,
    input  logic [WB_DW/8-1:0]   wbs_sel_i,
    input  logic                 wbs_we_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic [2:0]           wbs_cti_i,
    input  logic [1:0]           wbs_bte_i,
    output logic [WB_DW-1:0]     wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o
);

    localparam int SEL_W  = WB_DW / 8;
    localparam int RATIO  = WB_DW / OUT_DW;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    dma_state_e         state;
    logic [WB_DW-1:0]   start_adr;
    logic [WB_DW-1:0]   buf_size;
    logic [WB_DW-1:0]   burst_size;
    logic [WB_DW-1:0]   tx_cnt;
    logic               err_q;
    logic               done_q;
    logic               irq_en_q;
    logic               loop_q;
    logic [FIFO_AW:0]   beats_left;

    logic               slv_req;
    logic               slv_wr;
    logic [2:0]         reg_idx;
    logic [WB_DW-1:0]   wmask;
    logic [WB_DW-1:0]   wbits;
    logic [WB_DW-1:0]   ctrl_rd;
    logic               start_req;
    logic               busy;

    logic [WB_DW-1:0]   remaining;
    logic [WB_DW-1:0]   len_full;
    logic [FIFO_AW:0]   burst_len;
    logic [FIFO_AW:0]   free_words;
    logic               last_word;

    logic               fifo_wr;
    logic [WB_DW:0]     fifo_rdata;
    logic               fifo_rd;
    logic               fifo_empty;
    logic [FIFO_AW:0]   fifo_cnt;

    logic               unused_ok;

    assign wbm_dat_o = '0;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b0;
    assign wbm_bte_o = 2'b00;
    assign wbs_err_o = 1'b0;
    assign unused_ok = ^{wbs_adr_i[1:0], wbs_cti_i, wbs_bte_i};

    assign busy      = (state != IDLE);
    assign irq_o     = (done_q | err_q) & irq_en_q;
    assign slv_req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign slv_wr    = slv_req & wbs_we_i;
    assign reg_idx   = wbs_adr_i[4:2];
    assign wbits     = wbs_dat_i & wmask;
    assign start_req = slv_wr & (reg_idx == REG_CTRL) & wbits[CTRL_START];
    assign last_word = (tx_cnt + WB_DW'(1)) == buf_size;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < SEL_W; i++) begin
            wmask[8*i +: 8] = {8{wbs_sel_i[i]}};
        end
    end

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[CTRL_BUSY]   = busy;
        ctrl_rd[CTRL_ERR]    = err_q;
        ctrl_rd[CTRL_DONE]   = done_q;
        ctrl_rd[CTRL_IRQ_EN] = irq_en_q;
        ctrl_rd[CTRL_LOOP]   = loop_q;
    end

    // Burst length: BURST_SIZE (0 means 1), clamped to MAX_BURST_LEN and to what is left.
    always_comb begin
        remaining = buf_size - tx_cnt;
        len_full  = (burst_size == '0) ? WB_DW'(1) : burst_size;
        if (len_full > WB_DW'(MAX_BURST_LEN)) begin
            len_full = WB_DW'(MAX_BURST_LEN);
        end
        if (len_full > remaining) begin
            len_full = remaining;
        end
        burst_len  = len_full[FIFO_AW:0];
        free_words = (FIFO_AW+1)'(DEPTH) - fifo_cnt;
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments win,
    // so hardware set of done/err below overrides a same-cycle software clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_adr  <= '0;
            buf_size   <= '0;
            burst_size <= '0;
            tx_cnt     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            loop_q     <= 1'b0;
            beats_left <= '0;
            wbm_adr_o  <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_cti_o  <= 3'b000;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
        end else begin
            wbs_ack_o <= slv_req;
            if (slv_req) begin
                case (reg_idx)
                    REG_CTRL:       wbs_dat_o <= ctrl_rd;
                    REG_START_ADR:  wbs_dat_o <= start_adr;
                    REG_BUF_SIZE:   wbs_dat_o <= buf_size;
                    REG_BURST_SIZE: wbs_dat_o <= burst_size;
                    REG_TX_CNT:     wbs_dat_o <= tx_cnt;
                    default:        wbs_dat_o <= '0;
                endcase
            end
            if (slv_wr) begin
                case (reg_idx)
                    REG_CTRL: begin
                        if (wbits[CTRL_ERR])  err_q  <= 1'b0;
                        if (wbits[CTRL_DONE]) done_q <= 1'b0;
                        if (wbs_sel_i[0])     irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
`ifdef WB_STREAM_DMA_LOOP_EN
                        if (wbs_sel_i[0])     loop_q <= wbs_dat_i[CTRL_LOOP];
`endif
                    end
                    REG_START_ADR:  start_adr  <= (start_adr & ~wmask) | wbits;
                    REG_BUF_SIZE:   buf_size   <= (buf_size & ~wmask) | wbits;
                    REG_BURST_SIZE: burst_size <= (burst_size & ~wmask) | wbits;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (start_req) begin
                        err_q     <= 1'b0;
                        tx_cnt    <= '0;
                        wbm_adr_o <= WB_AW'(start_adr);
                        done_q    <= (buf_size == '0);
                        if (buf_size != '0) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (burst_len == '0) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else if (free_words >= burst_len) begin
                        state      <= BURST;
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        wbm_cti_o  <= (burst_len == (FIFO_AW+1)'(1)) ? CTI_EOB : CTI_INC;
                        beats_left <= burst_len;
                    end
                end
                BURST: begin
                    if (wbm_err_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_cti_o <= 3'b000;
                        err_q     <= 1'b1;
                        state     <= IDLE;
                    end else if (wbm_ack_i) begin
                        wbm_adr_o  <= wbm_adr_o + WB_AW'(SEL_W);
                        tx_cnt     <= tx_cnt + WB_DW'(1);
                        beats_left <= beats_left - (FIFO_AW+1)'(1);
                        if (beats_left == (FIFO_AW+1)'(2)) begin
                            wbm_cti_o <= CTI_EOB;
                        end
                        if (beats_left == (FIFO_AW+1)'(1)) begin
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            wbm_cti_o <= 3'b000;
                            state     <= WAIT;
                            if (last_word) begin
                                done_q <= 1'b1;
                                if (loop_q) begin
                                    wbm_adr_o <= WB_AW'(start_adr);
                                    tx_cnt    <= '0;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_wr = (state == BURST) & wbm_ack_i & ~wbm_err_i;

    wb_stream_sync_fifo #(
        .DW (WB_DW + 1),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data ({last_word, wbm_dat_i}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .cnt     (fifo_cnt)
    );

    // Serialiser: one FIFO word shifted out lowest lane first; refills on the final lane handshake.
    logic [WB_DW-1:0]  sh_word;
    logic              sh_last;
    logic              sh_valid;
    logic [LANE_W-1:0] lane;
    logic              beat_ok;
    logic              word_end;

    assign beat_ok  = sh_valid & stream_m_ready_i;
    assign word_end = beat_ok & (lane == LAST_LANE);
    assign fifo_rd  = ~fifo_empty & (~sh_valid | word_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_word  <= '0;
            sh_last  <= 1'b0;
            sh_valid <= 1'b0;
            lane     <= '0;
        end else if (fifo_rd) begin
            sh_word  <= fifo_rdata[WB_DW-1:0];
            sh_last  <= fifo_rdata[WB_DW];
            sh_valid <= 1'b1;
            lane     <= '0;
        end else if (word_end) begin
            sh_valid <= 1'b0;
            lane     <= '0;
        end else if (beat_ok) begin
            sh_word <= sh_word >> OUT_DW;
            lane    <= lane + LANE_W'(1);
        end
    end

    assign stream_m_data_o  = sh_word[OUT_DW-1:0];
    assign stream_m_valid_o = sh_valid;
    assign stream_m_last_o  = sh_valid & sh_last & (lane == LAST_LANE);

endmodule

// File: tb/tb_wb_stream_dma_writer.sv
// Self-checking bench for wb_stream_dma_writer: table-driven DMA jobs against a memory model,
// plus hand-written error, empty-buffer, loop-mode and mid-burst reset sequences.
module tb_wb_stream_dma_writer;
    import wb_stream_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = '0;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
    logic [7:0]  stream_m_data_o;
    logic        stream_m_valid_o, stream_m_last_o;
    logic        stream_m_ready_i = 1'b1;
    logic        irq_o;
    logic [4:0]  wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic [3:0]  wbs_sel_i = '0;
    logic        wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
    logic [2:0]  wbs_cti_i = '0;
    logic [1:0]  wbs_bte_i = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o;

    always #5 clk = ~clk;

    wb_stream_dma_writer dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
        .stream_m_ready_i(stream_m_ready_i), .stream_m_last_o(stream_m_last_o),
        .irq_o(irq_o),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory responder and stream sink, both acting on the falling edge.
    typedef struct packed { logic [31:0] adr; logic [2:0] cti; } beat_t;
    beat_t       beat_q[$];
    logic [8:0]  byte_q[$];
    int          job_id = 0;
    int          seen_job = 0;
    int          err_at = -1;
    bit          rand_ready = 1'b0;
    int          cyc_cycles = 0;

    always @(negedge clk) begin
        if (job_id != seen_job) begin
            seen_job = job_id;
            beat_q.delete();
            byte_q.delete();
            cyc_cycles = 0;
        end
        if (wbm_cyc_o) cyc_cycles++;
        if (wbm_ack_i || wbm_err_i) begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
        end else if (wbm_cyc_o && wbm_stb_o && rst_n) begin
            if (beat_q.size() == err_at) begin
                wbm_err_i = 1'b1;
            end else begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = word_at(wbm_adr_o);
                beat_q.push_back('{adr: wbm_adr_o, cti: wbm_cti_o});
            end
        end
        stream_m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stream_m_valid_o && stream_m_ready_i && rst_n)
            byte_q.push_back({stream_m_last_o, stream_m_data_o});
    end

    task automatic wb_access(input logic [2:0] idx, input logic we, input logic [31:0] d,
                             output logic [31:0] rd);
        bit got = 1'b0;
        rd = '0;
        @(negedge clk);
        wbs_adr_i = {idx, 2'b00};
        wbs_dat_i = d;
        wbs_sel_i = '1;
        wbs_we_i  = we;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                rd  = wbs_dat_o;
                got = 1'b1;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (!got) fail_now("wbs_ack");
    endtask

    task automatic wb_write(input logic [2:0] idx, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(idx, 1'b1, d, dummy);
    endtask

    task automatic wb_read(input logic [2:0] idx, output logic [31:0] rd);
        wb_access(idx, 1'b0, '0, rd);
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] c;
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            wb_read(REG_CTRL, c);
            if (!c[CTRL_BUSY]) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now(name);
    endtask

    task automatic wait_bytes(input string name, input int n);
        for (int i = 0; i < 2000 && byte_q.size() < n; i++) @(negedge clk);
        if (byte_q.size() < n) fail_now(name);
        repeat (12) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [31:0] start_adr;
        logic [31:0] buf_size;
        logic [31:0] burst_size;
        bit          rnd_ready;
        int          exp_bursts;
        int          exp_first_len;
        int          exp_last_len;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] rd;
        int nb, first_len, last_len, cur, bad, n;

        vecs[0] = '{"basic",    32'h100, 32'd10, 32'd4,  1'b0, 3,  4,  2};
        vecs[1] = '{"backpr",   32'h100, 32'd10, 32'd4,  1'b1, 3,  4,  2};
        vecs[2] = '{"burst0",   32'h200, 32'd5,  32'd0,  1'b0, 5,  1,  1};
        vecs[3] = '{"clamp",    32'h040, 32'd20, 32'd32, 1'b1, 2,  16, 4};
        vecs[4] = '{"oneword",  32'h300, 32'd1,  32'd4,  1'b0, 1,  1,  1};

        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst cyc", wbm_cyc_o, 0);
        check("rst stb", wbm_stb_o, 0);
        check("rst valid", stream_m_valid_o, 0);
        check("rst irq", irq_o, 0);
        wb_read(REG_CTRL, rd);
        check("rst ctrl", rd, 0);
        wb_read(REG_START_ADR, rd);
        check("rst start_adr", rd, 0);

        // Table-driven jobs
        for (int v = 0; v < 5; v++) begin
            job_id++;
            rand_ready = vecs[v].rnd_ready;
            err_at = -1;
            wb_write(REG_START_ADR, vecs[v].start_adr);
            wb_write(REG_BUF_SIZE, vecs[v].buf_size);
            wb_write(REG_BURST_SIZE, vecs[v].burst_size);
            wb_write(REG_CTRL, 32'h19);
            wait_idle($sformatf("%s idle", vecs[v].name));
            wait_bytes($sformatf("%s drain", vecs[v].name), 4 * int'(vecs[v].buf_size));

            wb_read(REG_CTRL, rd);
            check($sformatf("%s ctrl flags", vecs[v].name), rd & 32'hE, 32'h8);
            wb_read(REG_TX_CNT, rd);
            check($sformatf("%s tx_cnt", vecs[v].name), rd, vecs[v].buf_size);
            check($sformatf("%s irq", vecs[v].name), irq_o, 1);

            nb = 0; first_len = 0; last_len = 0; cur = 0; bad = 0;
            foreach (beat_q[k]) begin
                cur++;
                if (beat_q[k].cti == CTI_EOB) begin
                    nb++;
                    if (nb == 1) first_len = cur;
                    last_len = cur;
                    cur = 0;
                end else if (beat_q[k].cti != CTI_INC) begin
                    bad++;
                end
                if (beat_q[k].adr != vecs[v].start_adr + 32'(4 * k)) bad++;
            end
            if (cur != 0) bad++;
            check($sformatf("%s beats", vecs[v].name), beat_q.size(), vecs[v].buf_size);
            check($sformatf("%s bursts", vecs[v].name), nb, vecs[v].exp_bursts);
            check($sformatf("%s first_len", vecs[v].name), first_len, vecs[v].exp_first_len);
            check($sformatf("%s last_len", vecs[v].name), last_len, vecs[v].exp_last_len);
            check($sformatf("%s cti/adr errors", vecs[v].name), bad, 0);

            n = 4 * int'(vecs[v].buf_size);
            bad = 0;
            foreach (byte_q[j]) begin
                logic [31:0] w;
                w = word_at(vecs[v].start_adr + 32'(4 * (j / 4)));
                if (byte_q[j] !== {(j == n - 1), w[8 * (j % 4) +: 8]}) bad++;
            end
            check($sformatf("%s byte count", vecs[v].name), byte_q.size(), n);
            check($sformatf("%s byte errors", vecs[v].name), bad, 0);
        end
        rand_ready = 1'b0;

        // Bus error on the third beat of the first burst
        job_id++;
        err_at = 2;
        wb_write(REG_START_ADR, 32'h100);
        wb_write(REG_BUF_SIZE, 32'd10);
        wb_write(REG_BURST_SIZE, 32'd4);
        wb_write(REG_CTRL, 32'h19);
        wait_idle("err idle");
        wait_bytes("err drain", 8);
        wb_read(REG_CTRL, rd);
        check("err ctrl flags", rd & 32'hE, 32'h4);
        check("err irq", irq_o, 1);
        check("err cyc", wbm_cyc_o, 0);
        wb_read(REG_TX_CNT, rd);
        check("err tx_cnt", rd, 2);
        check("err beats", beat_q.size(), 2);
        check("err byte count", byte_q.size(), 8);
        bad = 0;
        foreach (byte_q[j]) begin
            logic [31:0] w;
            w = word_at(32'h100 + 32'(4 * (j / 4)));
            if (byte_q[j] !== {1'b0, w[8 * (j % 4) +: 8]}) bad++;
        end
        check("err byte errors", bad, 0);
        wb_write(REG_CTRL, 32'h14);
        @(negedge clk);
        check("err cleared irq", irq_o, 0);
        err_at = -1;

        // Empty buffer: done immediately, no bus cycle
        job_id++;
        wb_write(REG_BUF_SIZE, 32'd0);
        wb_write(REG_CTRL, 32'h19);
        wb_read(REG_CTRL, rd);
        check("buf0 ctrl flags", rd & 32'hE, 32'h8);
        repeat (10) @(negedge clk);
        check("buf0 cyc cycles", cyc_cycles, 0);
        check("buf0 irq", irq_o, 1);

`ifdef WB_STREAM_DMA_LOOP_EN
        // Ring mode: buffer repeats until loop is cleared
        job_id++;
        wb_write(REG_START_ADR, 32'h500);
        wb_write(REG_BUF_SIZE, 32'd3);
        wb_write(REG_BURST_SIZE, 32'd4);
        wb_write(REG_CTRL, 32'h39);
        for (int i = 0; i < 2000 && byte_q.size() < 30; i++) @(negedge clk);
        if (byte_q.size() < 30) fail_now("loop bytes");
        wb_write(REG_CTRL, 32'h10);
        wait_idle("loop idle");
        repeat (80) @(negedge clk);
        n = byte_q.size();
        check("loop total mod 12", n % 12, 0);
        check("loop >= 3 buffers", n >= 36, 1);
        check("loop beats", beat_q.size(), n / 4);
        bad = 0;
        foreach (byte_q[j]) begin
            logic [31:0] w;
            w = word_at(32'h500 + 32'(4 * ((j / 4) % 3)));
            if (byte_q[j] !== {(j % 12 == 11), w[8 * (j % 4) +: 8]}) bad++;
        end
        foreach (beat_q[k]) if (beat_q[k].adr != 32'h500 + 32'(4 * (k % 3))) bad++;
        check("loop data/adr errors", bad, 0);
`else
        wb_write(REG_CTRL, 32'h30);
        wb_read(REG_CTRL, rd);
        check("loop bit reads 0", rd[CTRL_LOOP], 0);
`endif

        // Reset in the middle of a burst
        job_id++;
        wb_write(REG_START_ADR, 32'h100);
        wb_write(REG_BUF_SIZE, 32'd10);
        wb_write(REG_BURST_SIZE, 32'd4);
        wb_write(REG_CTRL, 32'h19);
        for (int i = 0; i < 100 && !(wbm_cyc_o && beat_q.size() >= 1); i++) @(negedge clk);
        if (!(wbm_cyc_o && beat_q.size() >= 1)) fail_now("mid-burst cyc");
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst cyc", wbm_cyc_o, 0);
        check("midrst stb", wbm_stb_o, 0);
        check("midrst valid", stream_m_valid_o, 0);
        check("midrst irq", irq_o, 0);
        rst_n = 1'b1;
        n = beat_q.size();
        wb_read(REG_CTRL, rd);
        check("midrst ctrl", rd, 0);
        wb_read(REG_BUF_SIZE, rd);
        check("midrst buf_size", rd, 0);
        repeat (20) @(negedge clk);
        check("midrst no new beats", beat_q.size(), n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
